loop_index_bank: RTL and testbench

- Bank of NCH independent loop-index channels for the processor datapath. Each channel has an index register and a reference (limit) register.
- The controller selects one channel per cycle to write, increment or read it.
- Each channel drives a registered flag "index >= reference" that the control unit uses for loop-exit branching.
- Nested loops are handled by dedicating one channel per loop level. No index save/restore through memory is needed.

---
 rtl/loop_index_bank_pkg.sv | 7 +
 rtl/loop_index_bank_if.sv | 26 ++
 rtl/loop_index_bank_chan.sv | 43 ++++
 rtl/loop_index_bank.sv | 61 ++++++
 tb/tb_loop_index_bank.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/loop_index_bank_pkg.sv
// loop_index_bank_pkg: shared constants and types for the loop-index bank
package loop_index_bank_pkg;
  localparam int WIDTH_DEF = 16;
  localparam int IDX_RST = 0;
  localparam int REF_RST = 1;
  typedef logic [1:0] ch_sel_t;
endpackage

// File: rtl/loop_index_bank_if.sv
// loop_index_bank_if: controller-side bus of the loop-index bank (select, write/inc/read strobes, read data, flags, done)
interface loop_index_bank_if #(
  parameter int WIDTH = 16,
  parameter int NCH = 4,
  parameter int CH_W = 2
);
  logic [CH_W-1:0] ch_sel;
  logic write_i;
  logic write_iref;
  logic inc;
  logic read_i;
  logic read_iref;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_out_i;
  logic [WIDTH-1:0] data_out_iref;
  logic [NCH-1:0] iflag;
  logic done;
  modport master (
    output ch_sel, write_i, write_iref, inc, read_i, read_iref, data_in,
    input data_out_i, data_out_iref, iflag, done
  );
  modport slave (
    input ch_sel, write_i, write_iref, inc, read_i, read_iref, data_in,
    output data_out_i, data_out_iref, iflag, done
  );
endinterface

// File: rtl/loop_index_bank_chan.sv
// loop_index_chan: one index/reference pair with wrap/saturate incrementer and registered index>=reference flag; ports clk, rst, sel, write_i, write_iref, inc, data_in -> idx, iref, flag_next, flag
module loop_index_chan
  import loop_index_bank_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int STEP = 1,
  parameter int SATURATE = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic sel,
  input  logic write_i,
  input  logic write_iref,
  input  logic inc,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] idx,
  output logic [WIDTH-1:0] iref,
  output logic flag_next,
  output logic flag
);
  logic [WIDTH:0] sum;
  logic [WIDTH-1:0] inc_val;
  logic [WIDTH-1:0] idx_next;
  logic [WIDTH-1:0] iref_next;
  always_comb begin
    sum = {1'b0, idx} + (WIDTH+1)'(STEP);
    inc_val = (SATURATE != 0 && sum[WIDTH]) ? '1 : sum[WIDTH-1:0];
    idx_next = (sel && write_i) ? data_in : (sel && inc) ? inc_val : idx;
    iref_next = (sel && write_iref) ? data_in : iref;
    flag_next = idx_next >= iref_next;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      idx <= WIDTH'(IDX_RST);
      iref <= WIDTH'(REF_RST);
      flag <= 1'b0;
    end else begin
      idx <= idx_next;
      iref <= iref_next;
      flag <= flag_next;
    end
  end
endmodule

// File: rtl/loop_index_bank.sv
// loop_index_bank: NCH loop-index channels with per-channel index>=reference flags, registered reads and inc-caused done pulse; ports clk, rst, bus (slave)
module loop_index_bank
  import loop_index_bank_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int NCH = 4,
  parameter int CH_W = 2,
  parameter int STEP = 1,
  parameter int SATURATE = 0
) (
  input logic clk,
  input logic rst,
  loop_index_bank_if.slave bus
);
  logic [NCH-1:0] sel;
  logic [NCH-1:0] flag_v;
  logic [NCH-1:0] flag_nx;
  logic [WIDTH-1:0] idx_a [NCH];
  logic [WIDTH-1:0] iref_a [NCH];
  logic [WIDTH-1:0] rd_i;
  logic [WIDTH-1:0] rd_r;
  logic done_nx;
  for (genvar c = 0; c < NCH; c++) begin : g_ch
    // an out-of-range ch_sel matches no channel, so it writes nothing and reads 0
    assign sel[c] = bus.ch_sel == CH_W'(c);
    loop_index_chan #(.WIDTH(WIDTH), .STEP(STEP), .SATURATE(SATURATE)) u_chan (
      .clk(clk),
      .rst(rst),
      .sel(sel[c]),
      .write_i(bus.write_i),
      .write_iref(bus.write_iref),
      .inc(bus.inc),
      .data_in(bus.data_in),
      .idx(idx_a[c]),
      .iref(iref_a[c]),
      .flag_next(flag_nx[c]),
      .flag(flag_v[c])
    );
  end
  always_comb begin
    rd_i = '0;
    rd_r = '0;
    for (int c = 0; c < NCH; c++) begin
      rd_i = rd_i | (sel[c] ? idx_a[c] : '0);
      rd_r = rd_r | (sel[c] ? iref_a[c] : '0);
    end
    done_nx = bus.inc && !bus.write_i && |(sel & ~flag_v & flag_nx);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.data_out_i <= '0;
      bus.data_out_iref <= '0;
      bus.done <= 1'b0;
    end else begin
      bus.data_out_i <= bus.read_i ? rd_i : bus.data_out_i;
      bus.data_out_iref <= bus.read_iref ? rd_r : bus.data_out_iref;
      bus.done <= done_nx;
    end
  end
  assign bus.iflag = flag_v;
endmodule

// File: tb/tb_loop_index_bank.sv
// tb_loop_index_bank: directed and random checks of two bank instances (wrap STEP=1, saturate STEP=3) against a behavioural model
module tb_loop_index_bank;
  logic clk = 0;
  logic rst = 1;
  logic [1:0] ch_sel = 0;
  logic write_i = 0, write_iref = 0, inc = 0, read_i = 0, read_iref = 0;
  logic [3:0] data_in = 0;
  int n_cmp = 0, n_bad = 0;
  bit chk_on = 0;
  int m_idx [2][3];
  int m_ref [2][3];
  bit m_flag [2][3];
  int m_di [2], m_dr [2];
  bit m_done [2];

  always #5 clk = ~clk;

  loop_index_bank_if #(.WIDTH(4), .NCH(3), .CH_W(2)) ia ();
  loop_index_bank_if #(.WIDTH(4), .NCH(3), .CH_W(2)) ib ();
  assign ia.ch_sel = ch_sel;
  assign ia.write_i = write_i;
  assign ia.write_iref = write_iref;
  assign ia.inc = inc;
  assign ia.read_i = read_i;
  assign ia.read_iref = read_iref;
  assign ia.data_in = data_in;
  assign ib.ch_sel = ch_sel;
  assign ib.write_i = write_i;
  assign ib.write_iref = write_iref;
  assign ib.inc = inc;
  assign ib.read_i = read_i;
  assign ib.read_iref = read_iref;
  assign ib.data_in = data_in;

  loop_index_bank #(.WIDTH(4), .NCH(3), .CH_W(2), .STEP(1), .SATURATE(0)) u_wrap (.clk(clk), .rst(rst), .bus(ia));
  loop_index_bank #(.WIDTH(4), .NCH(3), .CH_W(2), .STEP(3), .SATURATE(1)) u_sat (.clk(clk), .rst(rst), .bus(ib));

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: instance 0 wraps mod 16 with step 1, instance 1 clamps at 15 with step 3
  always @(posedge clk) begin : model
    int ni [3];
    int nr [3];
    bit nf [3];
    int s;
    bit in_r;
    for (int k = 0; k < 2; k++) begin
      for (int c = 0; c < 3; c++) begin
        ni[c] = m_idx[k][c];
        nr[c] = m_ref[k][c];
        if (int'(ch_sel) == c) begin
          if (write_i) ni[c] = int'(data_in);
          else if (inc) begin
            s = m_idx[k][c] + (k == 1 ? 3 : 1);
            ni[c] = (k == 1) ? (s > 15 ? 15 : s) : s % 16;
          end
          if (write_iref) nr[c] = int'(data_in);
        end
        nf[c] = ni[c] >= nr[c];
      end
      in_r = ch_sel < 2'd3;
      for (int c = 0; c < 3; c++) begin
        m_idx[k][c] <= rst ? 0 : ni[c];
        m_ref[k][c] <= rst ? 1 : nr[c];
        m_flag[k][c] <= rst ? 1'b0 : nf[c];
      end
      m_done[k] <= !rst && in_r && inc && !write_i && !m_flag[k][ch_sel] && nf[ch_sel];
      m_di[k] <= rst ? 0 : read_i ? (in_r ? m_idx[k][ch_sel] : 0) : m_di[k];
      m_dr[k] <= rst ? 0 : read_iref ? (in_r ? m_ref[k][ch_sel] : 0) : m_dr[k];
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      for (int k = 0; k < 2; k++) begin
        logic [2:0] ef;
        for (int c = 0; c < 3; c++) ef[c] = m_flag[k][c];
        chk($sformatf("iflag%0d", k), 16'(k == 1 ? ib.iflag : ia.iflag), 16'(ef));
        chk($sformatf("done%0d", k), 16'(k == 1 ? ib.done : ia.done), 16'(m_done[k]));
        chk($sformatf("dout_i%0d", k), 16'(k == 1 ? ib.data_out_i : ia.data_out_i), 16'(m_di[k]));
        chk($sformatf("dout_iref%0d", k), 16'(k == 1 ? ib.data_out_iref : ia.data_out_iref), 16'(m_dr[k]));
      end
    end
  end

  task automatic step(input logic [1:0] s, input bit wi, input bit wr, input bit in,
                      input bit ri, input bit rr, input logic [3:0] d);
    ch_sel = s; write_i = wi; write_iref = wr; inc = in; read_i = ri; read_iref = rr; data_in = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    @(posedge clk);
    #1;
    chk_on = 1;
    step(0, 0, 0, 0, 0, 0, 0);
    rst = 0;
    chk("rst_iflag", 16'(ia.iflag), 16'd0);
    chk("rst_dout_i", 16'(ia.data_out_i), 16'd0);
    chk("rst_dout_iref", 16'(ia.data_out_iref), 16'd0);
    step(0, 0, 0, 0, 0, 1, 0);
    chk("rst_ref_is_1", 16'(ia.data_out_iref), 16'd1);
    step(1, 0, 1, 0, 0, 0, 3);
    step(1, 1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 1, 0, 0, 0);
    chk("cnt_inc1_flag", 16'(ia.iflag), 16'd0);
    step(1, 0, 0, 1, 0, 0, 0);
    chk("cnt_inc2_flag", 16'(ia.iflag), 16'd0);
    chk("cnt_inc2_done", 16'(ia.done), 16'd0);
    step(1, 0, 0, 1, 0, 0, 0);
    chk("cnt_inc3_flag", 16'(ia.iflag), 16'b010);
    chk("cnt_inc3_done", 16'(ia.done), 16'd1);
    step(1, 0, 0, 0, 0, 0, 0);
    chk("cnt_done_once", 16'(ia.done), 16'd0);
    step(2, 1, 0, 1, 0, 0, 5);
    step(2, 0, 0, 0, 1, 0, 0);
    chk("coll_write_wins", 16'(ia.data_out_i), 16'd5);
    step(2, 1, 0, 0, 1, 0, 9);
    chk("rbw_old", 16'(ia.data_out_i), 16'd5);
    step(2, 0, 0, 0, 1, 0, 0);
    chk("rbw_new", 16'(ia.data_out_i), 16'd9);
    step(0, 1, 0, 0, 0, 0, 15);
    step(0, 0, 0, 1, 1, 0, 0);
    chk("wrap_read_old", 16'(ia.data_out_i), 16'd15);
    chk("wrap_flag_fell", 16'(ia.iflag[0]), 16'd0);
    chk("wrap_no_done", 16'(ia.done), 16'd0);
    chk("sat_flag_held", 16'(ib.iflag[0]), 16'd1);
    step(0, 0, 0, 0, 1, 0, 0);
    chk("wrap_idx0", 16'(ia.data_out_i), 16'd0);
    chk("sat_idx15", 16'(ib.data_out_i), 16'd15);
    step(3, 1, 1, 1, 0, 0, 7);
    step(3, 0, 0, 0, 1, 1, 0);
    chk("oor_read_i", 16'(ia.data_out_i), 16'd0);
    chk("oor_read_iref", 16'(ia.data_out_iref), 16'd0);
    chk("oor_done", 16'(ia.done), 16'd0);
    step(0, 0, 1, 0, 0, 0, 2);
    step(0, 1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0);
    rst = 1;
    step(0, 0, 0, 1, 0, 0, 0);
    rst = 0;
    chk("mid_rst_flag", 16'(ia.iflag), 16'd0);
    chk("mid_rst_done", 16'(ia.done), 16'd0);
    step(0, 0, 0, 0, 1, 0, 0);
    chk("mid_rst_idx0", 16'(ia.data_out_i), 16'd0);
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 60) == 0);
      step(2'($urandom_range(0, 3)), $urandom_range(0, 5) == 0, $urandom_range(0, 6) == 0,
           $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
           4'($urandom_range(0, 15)));
    end
    rst = 0;
    step(0, 0, 0, 0, 0, 0, 0);
    chk_on = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
